// File: rtl/hmmm_pkg.sv
// ---------------------------------------------------------------------------
// hmmm_pkg
// Shared definitions for the Hmmm execute stage: default datapath and
// register-index widths, ALU opcode values, the execute-stage FSM state
// encoding and a small opcode helper.
// ---------------------------------------------------------------------------
package hmmm_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPRD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // True for the opcodes whose second operand acts as a divisor.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// ---------------------------------------------------------------------------
// hmmm_regfile
// NREGS x DATA_W register file with r0 hard-wired to zero.
// Ports:
//   clk, reset          clock / asynchronous active-high reset (clears all)
//   we, waddr, wdata    synchronous write port (writes to r0 are dropped)
//   raddr_a / rdata_a   asynchronous read port A
//   raddr_b / rdata_b   asynchronous read port B
//   dbg_addr / dbg_data asynchronous debug read port
// ---------------------------------------------------------------------------
module hmmm_regfile
  import hmmm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state of the array: a single entry replaced on a write to r1..rN.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 always reads as zero regardless of array content.
  assign rdata_a  = (raddr_a  == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : regs_q[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/hmmm_exec_stage.sv
// ---------------------------------------------------------------------------
// hmmm_exec_stage
// Execute-stage sequencer of the Hmmm core. Holds the register file and a
// four-state FSM (IDLE -> OPRD -> EXEC -> WB -> IDLE) that reads operands,
// drives an external combinational ALU, captures its outputs and writes the
// result back. A start sampled at edge N yields done high after edge N+3.
// Ports:
//   clk, reset               clock / asynchronous active-high reset
//   start, op, rd, ra, rb,   operation request from decode (sampled in IDLE)
//   use_imm, imm
//   busy, done, div0         status: not idle / writeback pulse / div-by-zero
//   flag_zero, flag_carry    sticky flags of the last completed op
//   alu_tmp1/2, alu_op,      registered ALU operands/opcode, enable in EXEC
//   alu_enable
//   alu_result/zero/carry    ALU outputs
//   dbg_addr / dbg_data      asynchronous register debug read
// ---------------------------------------------------------------------------
module hmmm_exec_stage
  import hmmm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [DATA_W-1:0] alu_tmp1,
  output logic [DATA_W-1:0] alu_tmp2,
  output logic [2:0]        alu_op,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] tmp1_q, tmp1_d;
  logic [DATA_W-1:0] tmp2_q, tmp2_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              div0_pend_q, div0_pend_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_zero_q, res_zero_d;
  logic              res_carry_q, res_carry_d;
  logic              flag_zero_q, flag_zero_d;
  logic              flag_carry_q, flag_carry_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
  logic              busy_q, busy_d;
  logic              alu_enable_q, alu_enable_d;

  logic              rf_we;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] operand_b;

  hmmm_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr_a  (ra_q),
    .rdata_a  (rdata_a),
    .raddr_b  (rb_q),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Second operand source; also the value tested for a zero divisor.
  assign operand_b = use_imm_q ? imm_q : rdata_b;

  // FSM next state, operand/result latches, writeback and status pulses.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    use_imm_d    = use_imm_q;
    imm_d        = imm_q;
    tmp1_d       = tmp1_q;
    tmp2_d       = tmp2_q;
    alu_op_d     = alu_op_q;
    div0_pend_d  = div0_pend_q;
    res_d        = res_q;
    res_zero_d   = res_zero_q;
    res_carry_d  = res_carry_q;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    done_d       = 1'b0;
    div0_d       = 1'b0;
    rf_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          rd_d      = rd;
          ra_d      = ra;
          rb_d      = rb;
          use_imm_d = use_imm;
          imm_d     = imm;
          state_d   = S_OPRD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_OPRD: begin
        // Operands are sampled here, so a same-op rd==ra/rb sees the old value.
        tmp1_d      = rdata_a;
        tmp2_d      = operand_b;
        alu_op_d    = op_q;
        div0_pend_d = is_div_op(op_q) && (operand_b == '0);
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        res_d       = alu_result;
        res_zero_d  = alu_zero;
        res_carry_d = alu_carry;
        state_d     = S_WB;
      end
      S_WB: begin
        done_d = 1'b1;
        if (div0_pend_q) begin
          // Divide by zero: report it, keep the register file and flags.
          div0_d = 1'b1;
          rf_we  = 1'b0;
        end else begin
          div0_d       = 1'b0;
          rf_we        = (rd_q != '0);
          flag_zero_d  = res_zero_q;
          flag_carry_d = res_carry_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    alu_enable_d = (state_d == S_EXEC);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      use_imm_q    <= 1'b0;
      imm_q        <= '0;
      tmp1_q       <= '0;
      tmp2_q       <= '0;
      alu_op_q     <= 3'd0;
      div0_pend_q  <= 1'b0;
      res_q        <= '0;
      res_zero_q   <= 1'b0;
      res_carry_q  <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
      done_q       <= 1'b0;
      div0_q       <= 1'b0;
      busy_q       <= 1'b0;
      alu_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      use_imm_q    <= use_imm_d;
      imm_q        <= imm_d;
      tmp1_q       <= tmp1_d;
      tmp2_q       <= tmp2_d;
      alu_op_q     <= alu_op_d;
      div0_pend_q  <= div0_pend_d;
      res_q        <= res_d;
      res_zero_q   <= res_zero_d;
      res_carry_q  <= res_carry_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
      done_q       <= done_d;
      div0_q       <= div0_d;
      busy_q       <= busy_d;
      alu_enable_q <= alu_enable_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign div0       = div0_q;
  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;
  assign alu_tmp1   = tmp1_q;
  assign alu_tmp2   = tmp2_q;
  assign alu_op     = alu_op_q;
  assign alu_enable = alu_enable_q;

endmodule

// File: tb/tb_hmmm_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_hmmm_exec_stage
// Bench for hmmm_exec_stage with a behavioural ALU, a transaction-level model
// of the register file/flags, a per-cycle compare process and directed ops
// with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_hmmm_exec_stage;
  import hmmm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [3:0]  rd = 4'd0, ra = 4'd0, rb = 4'd0;
  logic        use_imm = 1'b0;
  logic [15:0] imm = 16'd0;
  logic        busy, done, div0, flag_zero, flag_carry;
  logic [15:0] alu_tmp1, alu_tmp2;
  logic [2:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic        alu_zero, alu_carry;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  hmmm_exec_stage dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .ra(ra), .rb(rb),
    .use_imm(use_imm), .imm(imm), .busy(busy), .done(done), .div0(div0),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .alu_tmp1(alu_tmp1),
    .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour: {carry(signed overflow), zero, result}.
  function automatic logic [17:0] alu_fn(input logic [2:0] f, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0]        r;
    logic               c;
    logic signed [31:0] p;
    r = 16'd0;
    c = 1'b0;
    case (f)
      3'd0: begin r = a + b; c = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; c = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: begin
        p = $signed(a) * $signed(b);
        r = p[15:0];
        c = (p != {{16{r[15]}}, r});
      end
      3'd3: r = (b == 16'd0) ? 16'd0 : a / b;
      3'd4: r = (b == 16'd0) ? 16'd0 : a % b;
      default: r = 16'd0;
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  always_comb {alu_carry, alu_zero, alu_result} = alu_fn(alu_op, alu_tmp1, alu_tmp2);

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [15:0] m_r [16];
  logic        m_fz = 1'b0, m_fc = 1'b0, m_pend = 1'b0, m_done = 1'b0, m_div0 = 1'b0;
  logic        m_d0 = 1'b0, m_z = 1'b0, m_c = 1'b0;
  logic [15:0] m_t1 = 16'd0, m_t2 = 16'd0, m_res = 16'd0;
  logic [2:0]  m_op = 3'd0;
  logic [3:0]  m_rd = 4'd0;
  int          m_e = 0, m_acc_e = 0;
  logic        cmp_en = 1'b0;

  // An accepted op reads operands now and retires exactly three edges later.
  initial begin
    for (int i = 0; i < 16; i++) m_r[i] = 16'd0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 16; i++) m_r[i] = 16'd0;
        m_fz = 1'b0; m_fc = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_div0 = 1'b0;
      end else begin
        m_e++;
        m_done = 1'b0;
        m_div0 = 1'b0;
        if (m_pend) begin
          if (m_e == m_acc_e + 3) begin
            m_pend = 1'b0;
            m_done = 1'b1;
            m_div0 = m_d0;
            if (!m_d0) begin
              if (m_rd != 4'd0) m_r[m_rd] = m_res;
              m_fz = m_z;
              m_fc = m_c;
            end
          end
        end else if (start) begin
          m_pend  = 1'b1;
          m_acc_e = m_e;
          m_rd    = rd;
          m_op    = op;
          m_t1    = (ra == 4'd0) ? 16'd0 : m_r[ra];
          m_t2    = use_imm ? imm : ((rb == 4'd0) ? 16'd0 : m_r[rb]);
          m_d0    = ((op == 3'd3) || (op == 3'd4)) && (m_t2 == 16'd0);
          {m_c, m_z, m_res} = alu_fn(op, m_t1, m_t2);
        end
      end
    end
  end

  // Per-cycle comparison of DUT status/ALU-interface outputs against the model.
  initial begin
    logic en_exp;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        en_exp = m_pend && (m_e == m_acc_e + 1);
        chk1("busy", busy, m_pend);
        chk1("done", done, m_done);
        chk1("div0", div0, m_div0);
        chk1("flag_zero", flag_zero, m_fz);
        chk1("flag_carry", flag_carry, m_fc);
        chk1("alu_enable", alu_enable, en_exp);
        if (en_exp) begin
          chk16("alu_tmp1", alu_tmp1, m_t1);
          chk16("alu_tmp2", alu_tmp2, m_t2);
          chk16("alu_op", {13'd0, alu_op}, {13'd0, m_op});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int   lat;
  logic saw_div0;

  task automatic issue(input logic [2:0] f, input logic [3:0] d, input logic [3:0] a,
                       input logic [3:0] b, input logic ui, input logic [15:0] im);
    @(posedge clk); #2;
    op = f; rd = d; ra = a; rb = b; use_imm = ui; imm = im; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Edges after the accepting edge until done is seen (99 = never).
  task automatic wait_done(output int l, output logic d0);
    logic seen;
    seen = 1'b0;
    l    = 99;
    d0   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done && !seen) begin
        seen = 1'b1;
        l    = k - 1;
        d0   = div0;
      end
    end
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0]; #1;
      chk16($sformatf("r%0d", i), dbg_data, m_r[i]);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [3:0] d,
                       input logic [3:0] a, input logic [3:0] b, input logic ui,
                       input logic [15:0] im);
    issue(f, d, a, b, ui, im);
    wait_done(lat, saw_div0);
    chki({name, " latency"}, lat, 3);
    dump_regs();
  endtask

  task automatic chk_reg(input string name, input logic [3:0] idx, input logic [15:0] v);
    dbg_addr = idx; #1;
    chk16(name, dbg_data, v);
  endtask

  initial begin
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset flag_zero", flag_zero, 1'b0);
    chk16("reset alu_tmp1", alu_tmp1, 16'd0);
    dump_regs();

    // 1. preload and add
    do_op("ld r1", OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'd5);
    do_op("ld r2", OP_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 16'd7);
    do_op("add r3", OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 16'd0);
    chk_reg("lit r3", 4'd3, 16'd12);
    chk1("lit add zero", flag_zero, 1'b0);
    chk1("lit add carry", flag_carry, 1'b0);

    // 2. overflow and zero result
    do_op("ld r1", OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'h7FFF);
    do_op("ld r2", OP_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 16'd1);
    do_op("add r4", OP_ADD, 4'd4, 4'd1, 4'd2, 1'b0, 16'd0);
    chk_reg("lit r4", 4'd4, 16'h8000);
    chk1("lit ovf carry", flag_carry, 1'b1);
    do_op("sub r5", OP_SUB, 4'd5, 4'd1, 4'd1, 1'b0, 16'd0);
    chk_reg("lit r5", 4'd5, 16'd0);
    chk1("lit sub zero", flag_zero, 1'b1);
    chk1("lit sub carry", flag_carry, 1'b0);

    // 3. divide by zero (register and immediate divisor), then a normal mod
    do_op("ld r1", OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 16'd20);
    do_op("ld r6", OP_ADD, 4'd6, 4'd0, 4'd0, 1'b1, 16'h1234);
    do_op("sub r5", OP_SUB, 4'd5, 4'd1, 4'd1, 1'b0, 16'd0);
    do_op("div r6", OP_DIV, 4'd6, 4'd1, 4'd7, 1'b0, 16'd0);
    chk1("lit div0 pulse", saw_div0, 1'b1);
    chk_reg("lit r6 kept", 4'd6, 16'h1234);
    chk1("lit div0 zero held", flag_zero, 1'b1);
    do_op("mod imm0", OP_MOD, 4'd6, 4'd1, 4'd0, 1'b1, 16'd0);
    chk1("lit mod0 pulse", saw_div0, 1'b1);
    do_op("mod r10", OP_MOD, 4'd10, 4'd1, 4'd0, 1'b1, 16'd6);
    chk1("lit mod no div0", saw_div0, 1'b0);
    chk_reg("lit r10", 4'd10, 16'd2);

    // 4. write to r0 is dropped but flags update; ra==rd uses the old value
    do_op("sub r5", OP_SUB, 4'd5, 4'd1, 4'd1, 1'b0, 16'd0);
    do_op("add r0", OP_ADD, 4'd0, 4'd1, 4'd0, 1'b1, 16'd9);
    chk_reg("lit r0", 4'd0, 16'd0);
    chk1("lit r0 zero", flag_zero, 1'b0);
    do_op("inc r1", OP_ADD, 4'd1, 4'd1, 4'd0, 1'b1, 16'd1);
    chk_reg("lit r1", 4'd1, 16'd21);
    do_op("op5", 3'd5, 4'd11, 4'd1, 4'd2, 1'b0, 16'd0);
    chk_reg("lit r11", 4'd11, 16'd0);
    chk1("lit op5 zero", flag_zero, 1'b1);

    // 5. start held for six edges: two ops, one idle cycle between them
    begin
      int n_done, d1, d2, n_blow, blow_at;
      n_done = 0; d1 = -1; d2 = -1; n_blow = 0; blow_at = -1;
      @(posedge clk); #2;
      op = OP_ADD; rd = 4'd9; ra = 4'd9; rb = 4'd0; use_imm = 1'b1; imm = 16'd1;
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (done) begin
          n_done++;
          if (n_done == 1) d1 = k - 2; else d2 = k - 2;
        end
        if (!busy && k >= 2 && k <= 8) begin
          n_blow++;
          blow_at = k - 2;
        end
        if (k == 7) start = 1'b0;
      end
      chki("lit held ops", n_done, 2);
      chki("lit held done1", d1, 3);
      chki("lit held done2", d2, 7);
      chki("lit held idle cycles", n_blow, 1);
      chki("lit held idle at", blow_at, 3);
      chk_reg("lit r9", 4'd9, 16'd2);
    end

    // 6. reset during EXEC of a mul: nothing retires, then normal operation
    begin
      int n_done;
      n_done = 0;
      do_op("ld r8", OP_ADD, 4'd8, 4'd0, 4'd0, 1'b1, 16'd4);
      issue(OP_MUL, 4'd8, 4'd1, 4'd2, 1'b0, 16'd0);
      @(posedge clk); #2;
      chk1("lit exec enable", alu_enable, 1'b1);
      reset = 1'b1; #1;
      chk1("lit reset busy", busy, 1'b0);
      chk1("lit reset enable", alu_enable, 1'b0);
      @(posedge clk); #2;
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      chki("lit no done after reset", n_done, 0);
      chk_reg("lit r8 after reset", 4'd8, 16'd0);
      dump_regs();
      do_op("ld r8 post", OP_ADD, 4'd8, 4'd0, 4'd0, 1'b1, 16'd3);
      chk_reg("lit r8 post", 4'd8, 16'd3);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
